field_deser_95: RTL and testbench

- Serial receiver that recovers a parallel field word from a one-bit line.
- Counterpart of the field serializer: the serializer packs a, b/c, d, e, f into line x; this block unpacks them again.
- Sits in the link-side clock domain. Feeds the register/control layer with one strobe per received frame.

---
 rtl/field_deser_95.sv | 132 +++++++++++++
 tb/tb_field_deser_95.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/field_deser_95.sv
// Serial field receiver: recovers {f, e, d, b/c, a} from an LSB-first framed line
// sampled on bit_en_i, with optional even parity and framing-error recovery.
module field_deser_95 #(
   parameter int F_WIDTH   = 4,
   parameter bit USE_C     = 1'b0,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic               main_clk_i,
   input  logic               main_rst_an_i,
   input  logic               bit_en_i,
   input  logic               x_i,
   output logic               a_o,
   output logic               bc_o,
   output logic               d_o,
   output logic               e_o,
   output logic [F_WIDTH-1:0] f_o,
   output logic               valid_o,
   output logic               err_o,
   output logic               busy_o
);

   localparam int N  = 4 + F_WIDTH;
   localparam int CW = $clog2(N + 1);
   // b and c occupy the same frame slot; USE_C only selects which upstream field it carries.
   localparam int BC_POS = USE_C ? 1 : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DATA   = 3'd1,
      S_PARITY = 3'd2,
      S_STOP   = 3'd3,
      S_BREAK  = 3'd4
   } state_e;

   logic [1:0]    rsync_q;
   logic          rst_n;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  shift_q, shift_d;
   logic [N-1:0]  fields_q, fields_d;
   logic          par_q, par_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic          par_ok;

   // Reset asserts immediately, releases two clocks after the pin deasserts.
   always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
      if (!main_rst_an_i) rsync_q <= 2'b00;
      else                rsync_q <= {rsync_q[0], 1'b1};
   end
   assign rst_n = rsync_q[1];

   always_ff @(posedge main_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         fields_q <= '0;
         par_q    <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         fields_q <= fields_d;
         par_q    <= par_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   assign par_ok = PARITY_EN ? ~((^shift_q) ^ par_q) : 1'b1;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      fields_d = fields_q;
      par_d    = par_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      if (bit_en_i) begin
         unique case (state_q)
            S_IDLE: begin
               if (!x_i) begin
                  state_d = S_DATA;
                  cnt_d   = '0;
               end
            end
            S_DATA: begin
               // Right shift: after N bits the first payload bit (a) sits at bit 0.
               shift_d = {x_i, shift_q[N-1:1]};
               if (cnt_q != CW'(N)) cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(N - 1)) state_d = PARITY_EN ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
               par_d   = x_i;
               state_d = S_STOP;
            end
            S_STOP: begin
               if (x_i) begin
                  if (par_ok) begin
                     fields_d = shift_q;
                     valid_d  = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
                  state_d = S_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_BREAK;
               end
            end
            S_BREAK: begin
               if (x_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign a_o     = fields_q[0];
   assign bc_o    = fields_q[BC_POS];
   assign d_o     = fields_q[2];
   assign e_o     = fields_q[3];
   assign f_o     = fields_q[4 +: F_WIDTH];
   assign valid_o = valid_q;
   assign err_o   = err_q;
   assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_field_deser_95.sv
// Bench for field_deser_95: directed frame table, random frames against a frame-level
// model, a narrow parity-less instance with sparse bit_en, and mid-frame reset.
module tb_field_deser_95;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       bit_en = 1'b0, x = 1'b1;
   logic       a, bc, d, e, valid, err, busy;
   logic [3:0] f;
   logic       bit_en2 = 1'b0, x2 = 1'b1;
   logic       a2, c2, d2, e2, valid2, err2, busy2;
   logic [1:0] f2;

   field_deser_95 #(.F_WIDTH(4), .USE_C(1'b0), .PARITY_EN(1'b1)) dut (
      .main_clk_i(clk), .main_rst_an_i(rst_n), .bit_en_i(bit_en), .x_i(x),
      .a_o(a), .bc_o(bc), .d_o(d), .e_o(e), .f_o(f),
      .valid_o(valid), .err_o(err), .busy_o(busy));

   field_deser_95 #(.F_WIDTH(2), .USE_C(1'b1), .PARITY_EN(1'b0)) dut2 (
      .main_clk_i(clk), .main_rst_an_i(rst_n), .bit_en_i(bit_en2), .x_i(x2),
      .a_o(a2), .bc_o(c2), .d_o(d2), .e_o(e2), .f_o(f2),
      .valid_o(valid2), .err_o(err2), .busy_o(busy2));

   // clock / watchdog
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int n_cmp = 0;
   int n_err = 0;
   int dens  = 100;
   int v2_cnt = 0;
   logic [8:0] exp_q[$];   // {is_err, f, e, d, bc, a}
   logic [7:0] last_good = 8'h00;
   logic       prev_strobe = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // driver: hold a bit until an enabled edge; line is random in stalled cycles
   task automatic send_bit(input logic b);
      logic en;
      int   tries;
      tries = 0;
      do begin
         en = (dens >= 100) || ($urandom_range(0, 99) < dens) || (tries > 20);
         bit_en = en;
         x = en ? b : 1'($urandom_range(0, 1));
         tick();
         tries++;
      end while (!en);
      bit_en = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] pay, input logic bad_par, input logic bad_stop);
      logic par;
      par = (^pay) ^ bad_par;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(pay[i]);
      send_bit(par);
      send_bit(!bad_stop);
   endtask

   // frame-level reference model
   task automatic model_push(input logic [7:0] pay, input logic bad_par, input logic bad_stop);
      if (bad_par || bad_stop) exp_q.push_back({1'b1, last_good});
      else begin
         last_good = pay;
         exp_q.push_back({1'b0, pay});
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (valid || err) begin
         logic [8:0] ev;
         check("strobe_exclusive", {31'd0, valid & err}, 32'd0);
         check("strobe_one_cycle", {31'd0, prev_strobe}, 32'd0);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_strobe: got valid=%0b err=%0b want none", valid, err);
         end else begin
            ev = exp_q.pop_front();
            check("sb_event", {23'd0, err, f, e, d, bc, a}, {23'd0, ev});
         end
      end
      prev_strobe = valid | err;
      if (valid2) v2_cnt++;
   end

   task automatic send_bit2(input logic b);
      for (int i = 0; i < 2; i++) begin
         bit_en2 = 1'b0;
         x2 = 1'($urandom_range(0, 1));
         tick();
      end
      bit_en2 = 1'b1;
      x2 = b;
      tick();
      bit_en2 = 1'b0;
   endtask

   typedef struct {
      logic [7:0] pay;
      logic       bad_par;
      logic       bad_stop;
      int         gap;
      logic       exp_valid;
      logic       exp_err;
      logic [7:0] exp_fields;
   } vec_t;
   vec_t tbl[6];

   initial begin
      // payload byte = {f[3:0], e, d, b, a}
      tbl[0] = '{8'hAD, 1'b0, 1'b0, 1, 1'b1, 1'b0, 8'hAD};
      tbl[1] = '{8'hAD, 1'b1, 1'b0, 1, 1'b0, 1'b1, 8'hAD};
      tbl[2] = '{8'h32, 1'b0, 1'b1, 0, 1'b0, 1'b1, 8'hAD};
      tbl[3] = '{8'h30, 1'b0, 1'b0, 0, 1'b1, 1'b0, 8'h30};
      tbl[4] = '{8'h1B, 1'b0, 1'b0, 0, 1'b1, 1'b0, 8'h1B};
      tbl[5] = '{8'hF4, 1'b0, 1'b0, 2, 1'b1, 1'b0, 8'hF4};

      // reset
      tick();
      tick();
      check("rst_outputs", {25'd0, valid, err, busy, f, e, d, bc, a}, 32'd0);
      check("rst_outputs2", {25'd0, valid2, err2, busy2, f2, e2, d2, c2, a2}, 32'd0);
      rst_n = 1'b1;
      repeat (4) tick();
      check("post_rst_idle", {29'd0, valid, err, busy}, 32'd0);

      // directed table
      for (int i = 0; i < 6; i++) begin
         model_push(tbl[i].pay, tbl[i].bad_par, tbl[i].bad_stop);
         send_frame(tbl[i].pay, tbl[i].bad_par, tbl[i].bad_stop);
         check($sformatf("tbl%0d_valid", i), {31'd0, valid}, {31'd0, tbl[i].exp_valid});
         check($sformatf("tbl%0d_err", i), {31'd0, err}, {31'd0, tbl[i].exp_err});
         check($sformatf("tbl%0d_fields", i), {24'd0, f, e, d, bc, a}, {24'd0, tbl[i].exp_fields});
         check($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].bad_stop});
         if (tbl[i].bad_stop) begin
            for (int k = 0; k < 5; k++) begin
               send_bit(1'b0);
               check("break_hold", {29'd0, busy, valid, err}, 32'd4);
            end
            send_bit(1'b1);
            check("break_release", {31'd0, busy}, 32'd0);
         end else begin
            repeat (tbl[i].gap) send_bit(1'b1);
         end
      end

      // mid-frame async reset during bit d
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      bit_en = 1'b1;
      x = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_outputs", {25'd0, valid, err, busy, f, e, d, bc, a}, 32'd0);
      last_good = 8'h00;
      bit_en = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (4) tick();
      check("midrst_released", {25'd0, valid, err, busy, f, e, d, bc, a}, 32'd0);
      model_push(8'h5C, 1'b0, 1'b0);
      send_frame(8'h5C, 1'b0, 1'b0);
      check("midrst_frame_valid", {31'd0, valid}, 32'd1);
      check("midrst_frame_fields", {24'd0, f, e, d, bc, a}, 32'h5C);
      send_bit(1'b1);

      // random frames with stalls
      dens = 60;
      for (int n = 0; n < 40; n++) begin
         logic [7:0] pay;
         int kind;
         logic bp, bs;
         pay  = 8'($urandom);
         kind = $urandom_range(0, 5);
         bp   = (kind == 0);
         bs   = (kind == 1);
         model_push(pay, bp, bs);
         send_frame(pay, bp, bs);
         check("rand_latency", {31'd0, valid | err}, 32'd1);
         if (bs) begin
            repeat ($urandom_range(0, 3)) send_bit(1'b0);
            send_bit(1'b1);
         end
         repeat ($urandom_range(0, 2)) send_bit(1'b1);
      end
      dens = 100;
      repeat (3) tick();
      check("sb_drained", exp_q.size(), 32'd0);

      // narrow instance: no parity, bit_en every third cycle, line noisy when stalled
      send_bit2(1'b0);
      check("n2_busy_after_start", {31'd0, busy2}, 32'd1);
      send_bit2(1'b1);   // a
      send_bit2(1'b0);   // c
      send_bit2(1'b0);   // d
      send_bit2(1'b1);   // e
      send_bit2(1'b0);   // f[0]
      send_bit2(1'b1);   // f[1]
      check("n2_no_early_valid", v2_cnt, 32'd0);
      send_bit2(1'b1);   // stop
      check("n2_valid", {30'd0, valid2, err2}, 32'd2);
      check("n2_fields", {26'd0, f2, e2, d2, c2, a2}, {26'd0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1});
      repeat (4) tick();
      check("n2_single_strobe", v2_cnt, 32'd1);
      check("n2_idle", {31'd0, busy2}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
